alu_seq: RTL and testbench

- Parametrised, handshaked successor to the combinational zx/nx/zy/ny/f/no ALU. Operands are WIDTH bits wide.
- Adds registered outputs, a signed-overflow flag, valid/ready flow control on both sides, and an iterative multi-cycle signed multiply mode.
- Sits between the operand/decode stage and writeback. Downstream backpressure stalls the ALU instead of dropping results.

---
 rtl/alu_seq.sv | 173 +++++++++++++++++
 tb/tb_alu_seq.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: registered, handshaked Hack ALU (zx/nx/zy/ny/f/no) with a signed
// overflow flag and an iterative signed multiply mode.
//
//   state | meaning
//   IDLE  | no result held; ready to accept an operation
//   BUSY  | multiply in progress, one shift-add step per cycle
//   HOLD  | result registered on out/flags, waiting for out_ready
//
// Data ports use [0:WIDTH-1] (bit 0 = sign bit). They are copied into
// descending internal vectors so arithmetic reads naturally; the numeric value
// is unchanged by the copy.
module alu_seq #(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [0:5]       aluOperation,
  input  logic             mulEn,
  input  logic [0:WIDTH-1] x,
  input  logic [0:WIDTH-1] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [0:WIDTH-1] out,
  output logic             zr,
  output logic             ng,
  output logic             ov
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t state;

  logic             op_zx, op_nx, op_zy, op_ny, op_f, op_no;
  logic [WIDTH-1:0] x_in, y_in;
  logic [WIDTH-1:0] x_pre, y_pre;
  logic [WIDTH-1:0] hack_sum, hack_r, hack_res;
  logic             hack_ov;
  logic             mul_req;
  logic             accept;

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CW-1:0]      cnt;
  logic               mul_no;
  logic [2*WIDTH-1:0] addend;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mul_lo, mul_res;
  logic               mul_ov;

  assign op_zx = aluOperation[0];
  assign op_nx = aluOperation[1];
  assign op_zy = aluOperation[2];
  assign op_ny = aluOperation[3];
  assign op_f  = aluOperation[4];
  assign op_no = aluOperation[5];

  assign x_in = x;
  assign y_in = y;

  // Multiply is only honoured when the mode is built in.
  assign mul_req = mulEn & MUL_EN;

  // IDLE always accepts; HOLD accepts only when the held result leaves on the same edge.
  assign in_ready = rst_n & ((state == IDLE) | ((state == HOLD) & out_ready));
  assign accept   = in_valid & in_ready;

  // Operand preprocessing and the single-cycle Hack datapath.
  always_comb begin
    x_pre    = op_zx ? '0 : x_in;
    x_pre    = op_nx ? ~x_pre : x_pre;
    y_pre    = op_zy ? '0 : y_in;
    y_pre    = op_ny ? ~y_pre : y_pre;
    hack_sum = x_pre + y_pre;
    hack_r   = op_f ? hack_sum : (x_pre & y_pre);
    hack_res = op_no ? ~hack_r : hack_r;
    // Overflow is judged on the raw sum, before the optional output inversion.
    hack_ov  = op_f & (x_pre[WIDTH-1] == y_pre[WIDTH-1])
                    & (hack_sum[WIDTH-1] != x_pre[WIDTH-1]);
  end

  // One multiply step and the final product formatting.
  // The multiplier's sign bit carries weight -2^(WIDTH-1), so the last step
  // subtracts the shifted multiplicand instead of adding it.
  always_comb begin
    addend   = mplier[0] ? mcand : '0;
    acc_next = (cnt == CNT_LAST) ? (acc - addend) : (acc + addend);
    mul_lo   = acc[WIDTH-1:0];
    mul_res  = mul_no ? ~mul_lo : mul_lo;
    mul_ov   = (acc[2*WIDTH-1:WIDTH] != {WIDTH{acc[WIDTH-1]}});
  end

  // Control FSM with registered result, flags and out_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      ov        <= 1'b0;
      out_valid <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      mul_no    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
        end
        BUSY: begin
          if (cnt != '0) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - CNT_LAST;
          end else begin
            out       <= mul_res;
            zr        <= (mul_res == '0);
            ng        <= mul_res[WIDTH-1];
            ov        <= mul_ov;
            out_valid <= 1'b1;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase

      // A new operation overrides the per-state defaults above. Accept only
      // happens from IDLE or from HOLD together with a handoff.
      if (accept) begin
        if (mul_req) begin
          acc       <= '0;
          mcand     <= {{WIDTH{x_pre[WIDTH-1]}}, x_pre};
          mplier    <= y_pre;
          cnt       <= CNT_LOAD;
          mul_no    <= op_no;
          out_valid <= 1'b0;
          state     <= BUSY;
        end else begin
          out       <= hack_res;
          zr        <= (hack_res == '0);
          ng        <= hack_res[WIDTH-1];
          ov        <= hack_ov;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [0:5]  aluOperation;
  logic        mulEn;
  logic        out_ready;

  logic [0:31] x32, y32, out32;
  logic        in_ready32, out_valid32, zr32, ng32, ov32;
  logic [0:7]  x8, y8, out8;
  logic        in_ready8, out_valid8, zr8, ng8, ov8;

  int n_cmp = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(32), .MUL_EN(1'b1)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .aluOperation(aluOperation), .mulEn(mulEn), .x(x32), .y(y32),
    .out_valid(out_valid32), .out_ready(out_ready), .out(out32),
    .zr(zr32), .ng(ng32), .ov(ov32)
  );

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready8),
    .aluOperation(aluOperation), .mulEn(mulEn), .x(x8), .y(y8),
    .out_valid(out_valid8), .out_ready(out_ready), .out(out8),
    .zr(zr8), .ng(ng8), .ov(ov8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic longint sext(input longint v, input int w);
    longint m, s;
    m = (longint'(1) << w) - 1;
    s = longint'(1) << (w - 1);
    return ((v & m) ^ s) - s;
  endfunction

  // Reference: plain integer arithmetic on the preprocessed operands.
  task automatic model(input int w, input logic [0:5] op, input logic m,
                       input longint xv, input longint yv,
                       output longint r, output logic zf, output logic ngf, output logic ovf);
    longint mask, xp, yp, sx, sy, full;
    mask = (longint'(1) << w) - 1;
    xp = op[0] ? 64'sd0 : (xv & mask);
    if (op[1]) xp = ~xp & mask;
    yp = op[2] ? 64'sd0 : (yv & mask);
    if (op[3]) yp = ~yp & mask;
    sx = sext(xp, w);
    sy = sext(yp, w);
    if (m) begin
      full = sx * sy;
      r    = full & mask;
      ovf  = (full != sext(r, w));
    end else if (op[4]) begin
      full = sx + sy;
      r    = full & mask;
      ovf  = (full != sext(r, w));
    end else begin
      r   = xp & yp;
      ovf = 1'b0;
    end
    if (op[5]) r = ~r & mask;
    zf  = (r == 0);
    ngf = ((r >> (w - 1)) & 1) != 0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Offers one operation to both DUTs, waits for both results, checks them
  // against the model, optionally stalls, then hands both results off.
  task automatic run_op(input logic [0:5] op, input logic m, input logic [31:0] xv,
                        input logic [31:0] yv, input int stall,
                        output logic [31:0] r32, output logic [2:0] f32, output int l32,
                        output logic [7:0] r8, output logic [2:0] f8, output int l8);
    int     cyc;
    longint er;
    logic   ez, eng, eov;
    r32 = 'x; f32 = 'x; r8 = 'x; f8 = 'x;
    chk("in_ready32 idle", in_ready32, 1);
    chk("in_ready8 idle", in_ready8, 1);
    @(negedge clk);
    in_valid = 1'b1; aluOperation = op; mulEn = m;
    x32 = xv; y32 = yv; x8 = xv[7:0]; y8 = yv[7:0];
    @(posedge clk); #1;
    in_valid = 1'b0;
    x32 = $urandom; y32 = $urandom; x8 = 8'($urandom); y8 = 8'($urandom);
    aluOperation = 6'($urandom); mulEn = 1'($urandom);
    l32 = -1; l8 = -1; cyc = 0;
    if (out_valid32) begin l32 = 0; r32 = out32; f32 = {zr32, ng32, ov32}; end
    if (out_valid8)  begin l8 = 0;  r8 = out8;   f8 = {zr8, ng8, ov8};     end
    while ((l32 < 0 || l8 < 0) && cyc < 80) begin
      if (l32 < 0) chk("in_ready32 busy", in_ready32, 0);
      if (l8 < 0)  chk("in_ready8 busy", in_ready8, 0);
      @(posedge clk); #1;
      cyc++;
      if (l32 < 0 && out_valid32) begin l32 = cyc; r32 = out32; f32 = {zr32, ng32, ov32}; end
      if (l8 < 0 && out_valid8)   begin l8 = cyc;  r8 = out8;   f8 = {zr8, ng8, ov8};     end
    end
    repeat (stall) begin
      @(posedge clk); #1;
      chk("stall out32", out32, r32);
      chk("stall flags32", {zr32, ng32, ov32}, f32);
      chk("stall valid32", out_valid32, 1);
      chk("stall in_ready32", in_ready32, 0);
    end
    chk("hold8 stable", {out8, zr8, ng8, ov8}, {r8, f8});
    model(32, op, m, longint'(xv), longint'(yv), er, ez, eng, eov);
    chk("model out32", r32, er);
    chk("model flags32", f32, {ez, eng, eov});
    chk("latency32", l32, m ? 33 : 0);
    model(8, op, m, longint'(xv), longint'(yv), er, ez, eng, eov);
    chk("model out8", r8, er);
    chk("model flags8", f8, {ez, eng, eov});
    chk("latency8", l8, m ? 9 : 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("handoff valid32", out_valid32, 0);
    chk("handoff valid8", out_valid8, 0);
    chk("keep out32", out32, r32);
    chk("keep flags32", {zr32, ng32, ov32}, f32);
  endtask

  typedef struct {
    logic [0:5]  op;
    logic        m;
    logic [31:0] xv;
    logic [31:0] yv;
    logic [31:0] eo;
    logic        ez;
    logic        eng;
    logic        eov;
  } vec_t;

  vec_t tbl[12];

  initial begin
    logic [31:0] r32;
    logic [2:0]  f32;
    logic [7:0]  r8;
    logic [2:0]  f8;
    int          l32, l8, cyc;
    logic        seen;

    tbl[0]  = '{6'b000010, 1'b0, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0, 1'b0};
    tbl[1]  = '{6'b010011, 1'b0, 32'd3,          32'd10,         32'hFFFF_FFF9,  1'b0, 1'b1, 1'b0};
    tbl[2]  = '{6'b101010, 1'b0, 32'd123,        32'd456,        32'd0,          1'b1, 1'b0, 1'b0};
    tbl[3]  = '{6'b000010, 1'b0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1, 1'b1};
    tbl[4]  = '{6'b000000, 1'b0, 32'h7FFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0, 1'b0};
    tbl[5]  = '{6'b000000, 1'b1, 32'hFFFF_FFFA,  32'd7,          32'hFFFF_FFD6,  1'b0, 1'b1, 1'b0};
    tbl[6]  = '{6'b000000, 1'b1, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b1, 1'b0, 1'b1};
    tbl[7]  = '{6'b000001, 1'b1, 32'd3,          32'd5,          32'hFFFF_FFF0,  1'b0, 1'b1, 1'b0};
    tbl[8]  = '{6'b001100, 1'b0, 32'h8000_0001,  32'h1234_5678,  32'h8000_0001,  1'b0, 1'b1, 1'b0};
    tbl[9]  = '{6'b000010, 1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0, 1'b0};
    tbl[10] = '{6'b000000, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 1'b1, 1'b1};
    tbl[11] = '{6'b000010, 1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'h7FFF_FFFF,  1'b0, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mulEn = 1'b0;
    aluOperation = '0; x32 = '0; y32 = '0; x8 = '0; y8 = '0;

    // Reset held for three cycles.
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready32", in_ready32, 0);
    chk("rst in_ready8", in_ready8, 0);
    chk("rst out_valid32", out_valid32, 0);
    chk("rst out32", out32, 0);
    chk("rst flags32", {zr32, ng32, ov32}, 3'b000);
    chk("rst out8", {out8, zr8, ng8, ov8}, 11'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-rst in_ready32", in_ready32, 1);
    chk("post-rst out_valid32", out_valid32, 0);

    // Directed vectors.
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].m, tbl[i].xv, tbl[i].yv, 0, r32, f32, l32, r8, f8, l8);
      chk($sformatf("tbl%0d out", i), r32, tbl[i].eo);
      chk($sformatf("tbl%0d flags", i), f32, {tbl[i].ez, tbl[i].eng, tbl[i].eov});
    end

    // Narrow-width corners.
    run_op(6'b000010, 1'b0, 32'h7F, 32'h01, 0, r32, f32, l32, r8, f8, l8);
    chk("w8 add out", r8, 8'h80);
    chk("w8 add flags", f8, 3'b011);
    run_op(6'b000000, 1'b1, 32'hFFFF_FFF8, 32'd16, 0, r32, f32, l32, r8, f8, l8);
    chk("w8 mul out", r8, 8'h80);
    chk("w8 mul flags", f8, 3'b010);
    chk("w8 mul latency", l8, 9);

    // Backpressure, then back-to-back Hack accept, then handoff plus multiply accept.
    @(negedge clk);
    in_valid = 1'b1; aluOperation = 6'b000010; mulEn = 1'b0;
    x32 = 32'd5; y32 = 32'd7; x8 = 8'd5; y8 = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0; x32 = $urandom; y32 = $urandom;
    chk("bp first out", out32, 32'd12);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp held out", {out32, zr32, ng32, ov32}, {32'd12, 3'b000});
      chk("bp held valid", out_valid32, 1);
      chk("bp in_ready", in_ready32, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; aluOperation = 6'b000010; mulEn = 1'b0;
    x32 = 32'd1; y32 = 32'd1; x8 = 8'd1; y8 = 8'd1;
    #1;
    chk("bp in_ready follows out_ready", in_ready32, 1);
    @(posedge clk); #1;
    chk("b2b out", out32, 32'd2);
    chk("b2b valid", out_valid32, 1);
    chk("b2b out8", out8, 8'd2);
    mulEn = 1'b1; aluOperation = 6'b000000;
    x32 = 32'd3; y32 = 32'd4; x8 = 8'd3; y8 = 8'd4;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("hold->busy valid", out_valid32, 0);
    chk("hold->busy in_ready", in_ready32, 0);
    cyc = 0;
    while (!out_valid32 && cyc < 80) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold->busy latency", cyc, 33);
    chk("hold->busy out", out32, 32'd12);
    chk("hold->busy out8", out8, 8'd12);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;

    // Randomized operations against the model.
    for (int i = 0; i < 150; i++) begin
      run_op(6'($urandom), 1'($urandom), pick(), pick(), $urandom_range(0, 3),
             r32, f32, l32, r8, f8, l8);
    end

    // Reset in the middle of a multiply: nothing may come out afterwards.
    @(negedge clk);
    in_valid = 1'b1; aluOperation = 6'b000000; mulEn = 1'b1;
    x32 = 32'hFFFF_FFFA; y32 = 32'd7; x8 = 8'hFA; y8 = 8'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst in_ready32", in_ready32, 0);
    chk("midrst out_valid32", out_valid32, 0);
    chk("midrst out32", out32, 0);
    chk("midrst out_valid8", out_valid8, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst release in_ready32", in_ready32, 1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid32 || out_valid8) seen = 1'b1;
    end
    chk("midrst no stale result", seen, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
